// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 fetch stage.
package lc3_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STALL,
      REDIRECT
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] npc;
   } fetch_entry_s;

   localparam logic [15:0] LC3_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_fetch_buf.sv
// Small synchronous FIFO of fetched instructions; flush wins over push and pop.
module lc3_fetch_buf
   import lc3_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         push,
   input  fetch_entry_s push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_s head,
   output logic [CW-1:0] count,
   output logic         empty,
   output logic         full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_s    mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            push_ok;
   logic            pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // Head register keeps its contents so decode outputs hold their last value
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
         if (push_ok & ~pop_ok)      count <= count + 1'b1;
         else if (~push_ok & pop_ok) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: PC, fetch state machine, one-deep inflight read tracking
// and the issue decision feeding a small decode-side FIFO.
module lc3_fetch_unit
   import lc3_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = LC3_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_fetch_i,
   input  logic        br_taken_i,
   input  logic [15:0] taddr_i,
   output logic        imem_rd_o,
   output logic [15:0] imem_addr_o,
   input  logic [15:0] imem_dout_i,
   input  logic        decode_ready_i,
   output logic        enable_decode_o,
   output logic [15:0] instr_dout_o,
   output logic [15:0] npc_in_o,
   output logic [15:0] pc_o
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_e  state;
   fetch_state_e  state_next;
   logic [15:0]   pc;
   logic          vld_p1;
   logic [15:0]   tag_p1;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic          room;
   logic          issue;
   fetch_entry_s  head;
   fetch_entry_s  ret_entry;

   assign pop = enable_decode_o & decode_ready_i;

   // An outstanding read already owns a slot, so it is counted against the room
   always_comb begin
      if (vld_p1) room = (int'(count) + 1) < (BUF_DEPTH + int'(pop));
      else        room = ~full | pop;
   end

   assign issue       = (state == RUN) & enable_fetch_i & ~br_taken_i & room;
   assign push        = vld_p1 & ~br_taken_i;
   assign ret_entry   = '{instr: imem_dout_i, npc: tag_p1};
   assign imem_rd_o   = issue;
   assign imem_addr_o = pc;
   assign pc_o        = pc;

   always_comb begin
      state_next = state;
      if (br_taken_i) begin
         state_next = REDIRECT;
      end else begin
         case (state)
            IDLE:     if (enable_fetch_i)  state_next = RUN;
            RUN:      if (!enable_fetch_i) state_next = STALL;
            STALL:    if (enable_fetch_i)  state_next = RUN;
            REDIRECT: state_next = enable_fetch_i ? RUN : STALL;
            default:  state_next = IDLE;
         endcase
      end
   end

   // Issue stage -> return stage: vld_p1/tag_p1 describe the read on the bus
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         vld_p1 <= 1'b0;
         tag_p1 <= '0;
      end else begin
         state <= state_next;
         if (br_taken_i) begin
            pc     <= taddr_i;
            vld_p1 <= 1'b0;
         end else if (issue) begin
            pc     <= pc + 16'd1;
            vld_p1 <= 1'b1;
            tag_p1 <= pc + 16'd1;
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   lc3_fetch_buf #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .push       (push),
      .push_entry (ret_entry),
      .pop        (pop),
      .flush      (br_taken_i),
      .head       (head),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   assign enable_decode_o = ~empty;
   assign instr_dout_o    = head.instr;
   assign npc_in_o        = head.npc;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Randomised bench for lc3_fetch_unit against a queue-based fetch model.
module tb_lc3_fetch_unit;

   localparam int DEPTH = 2;

   logic        clock_i        = 1'b0;
   logic        reset_i        = 1'b0;
   logic        enable_fetch_i = 1'b0;
   logic        br_taken_i     = 1'b0;
   logic [15:0] taddr_i        = '0;
   logic [15:0] imem_dout_i    = '0;
   logic        decode_ready_i = 1'b0;
   logic        imem_rd_o;
   logic [15:0] imem_addr_o;
   logic        enable_decode_o;
   logic [15:0] instr_dout_o;
   logic [15:0] npc_in_o;
   logic [15:0] pc_o;

   int total = 0;
   int bad   = 0;

   // Model: queue of {instr, npc}, one outstanding read, and whether fetching is allowed
   logic [31:0] q[$];
   bit          m_inf;
   logic [15:0] m_inf_addr;
   logic [15:0] m_pc;
   bit          m_run_ok;

   lc3_fetch_unit #(
      .RESET_PC  (16'h3000),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .enable_fetch_i  (enable_fetch_i),
      .br_taken_i      (br_taken_i),
      .taddr_i         (taddr_i),
      .imem_rd_o       (imem_rd_o),
      .imem_addr_o     (imem_addr_o),
      .imem_dout_i     (imem_dout_i),
      .decode_ready_i  (decode_ready_i),
      .enable_decode_o (enable_decode_o),
      .instr_dout_o    (instr_dout_o),
      .npc_in_o        (npc_in_o),
      .pc_o            (pc_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a + 16'h1000;
   endfunction

   // Synchronous instruction memory: data valid the cycle after the strobe
   always @(posedge clock_i) if (imem_rd_o) imem_dout_i <= mem_word(imem_addr_o);

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_pop();
      return (q.size() != 0) && decode_ready_i;
   endfunction

   function automatic bit m_issue();
      int used;
      used = q.size() + int'(m_inf) - int'(m_pop());
      return m_run_ok && enable_fetch_i && !br_taken_i && (used < DEPTH);
   endfunction

   task automatic model_reset();
      q.delete();
      m_inf      = 1'b0;
      m_inf_addr = '0;
      m_pc       = 16'h3000;
      m_run_ok   = 1'b0;
   endtask

   task automatic model_step();
      bit p;
      bit iss;
      p   = m_pop();
      iss = m_issue();
      if (br_taken_i) begin
         q.delete();
         m_inf = 1'b0;
         m_pc  = taddr_i;
      end else begin
         if (p) void'(q.pop_front());
         if (m_inf) q.push_back({mem_word(m_inf_addr), m_inf_addr + 16'd1});
         if (iss) begin
            m_inf      = 1'b1;
            m_inf_addr = m_pc;
            m_pc       = m_pc + 16'd1;
         end else begin
            m_inf = 1'b0;
         end
      end
      m_run_ok = enable_fetch_i && !br_taken_i;
   endtask

   task automatic check_outputs();
      chk("imem_rd", 16'(imem_rd_o), 16'(m_issue()));
      chk("imem_addr", imem_addr_o, m_pc);
      chk("pc", pc_o, m_pc);
      chk("enable_decode", 16'(enable_decode_o), 16'(q.size() != 0));
      if (q.size() != 0) begin
         chk("instr", instr_dout_o, q[0][31:16]);
         chk("npc", npc_in_o, q[0][15:0]);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_imem_rd", 16'(imem_rd_o), 16'h0);
      chk("rst_enable_decode", 16'(enable_decode_o), 16'h0);
      chk("rst_instr", instr_dout_o, 16'h0);
      chk("rst_npc", npc_in_o, 16'h0);
      chk("rst_addr", imem_addr_o, 16'h3000);
      chk("rst_pc", pc_o, 16'h3000);
   endtask

   task automatic cyc();
      @(negedge clock_i);
      check_outputs();
      @(posedge clock_i);
      model_step();
      #1;
   endtask

   task automatic drive(input bit en, input bit rdy, input bit br, input logic [15:0] ta);
      enable_fetch_i = en;
      decode_ready_i = rdy;
      br_taken_i     = br;
      taddr_i        = ta;
   endtask

   initial begin
      reset_i = 1'b1;
      @(posedge clock_i);
      #1;
      check_reset_vals();
      model_reset();
      reset_i = 1'b0;

      // Streaming from reset with decode always ready
      drive(1, 1, 0, 16'h0);
      repeat (20) cyc();

      // Decode back-pressure then release
      drive(1, 0, 0, 16'h0);
      repeat (6) cyc();
      drive(1, 1, 0, 16'h0);
      repeat (8) cyc();

      // Redirect while the FIFO is full, then while streaming with a read inflight
      drive(1, 0, 0, 16'h0);
      repeat (4) cyc();
      drive(1, 0, 1, 16'h0200);
      cyc();
      drive(1, 1, 0, 16'h0);
      repeat (8) cyc();
      drive(1, 1, 1, 16'h0200);
      cyc();
      drive(1, 1, 0, 16'h0);
      repeat (6) cyc();

      // PC wrap-around
      drive(1, 1, 1, 16'hFFFE);
      cyc();
      drive(1, 1, 0, 16'h0);
      repeat (8) cyc();

      // Fetch enable toggling every cycle, random decode readiness
      for (int i = 0; i < 40; i++) begin
         drive((i % 2) == 0, $urandom_range(0, 1) == 1, 0, 16'h0);
         cyc();
      end

      // Fully random traffic including back-to-back redirects
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 15) == 0, 16'($urandom));
         cyc();
      end

      // Asynchronous reset in the middle of a stream with a read outstanding
      drive(1, 1, 0, 16'h0);
      repeat (6) cyc();
      reset_i = 1'b1;
      #1;
      check_reset_vals();
      model_reset();
      @(posedge clock_i);
      #1;
      check_reset_vals();
      reset_i = 1'b0;
      repeat (10) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
